// File: rtl/gearbox_pkg.sv
// Shared types and helpers for the multi-channel fractional clock-enable generator.
package gearbox_pkg;
  localparam int DW_DEF  = 8;
  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = (NCH_DEF > 1) ? $clog2(NCH_DEF) : 1;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [CW_DEF-1:0] chan;
    logic [DW_DEF-1:0] num;
    logic              en;
    logic              imm;
  } cfg_t;
endpackage

// File: rtl/gearbox_ch.sv
// One gearbox channel: phase accumulator, live ratio/enable and a deferred update slot.
module gearbox_ch #(
  parameter int DW  = 8,
  parameter int FD0 = 2**(DW-1)-1,
  parameter int EN0 = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          imm,
  input  logic          align,
  input  logic [DW-1:0] num_i,
  input  logic          en_i,
  output logic          gen,
  output logic          pend
);
  logic [DW:0]   acc_q, acc_d, sum;
  logic [DW-1:0] num_q, num_d, nxt_num_q, nxt_num_d;
  logic          en_q, en_d, nxt_en_q, nxt_en_d;
  logic          pend_q, pend_d, gen_q, gen_d;

  always_comb begin
    sum       = {1'b0, acc_q[DW-1:0]} + {1'b0, num_q} + (DW+1)'(1);
    acc_d     = en_q ? sum : '0;
    gen_d     = acc_q[DW];
    num_d     = num_q;
    en_d      = en_q;
    nxt_num_d = nxt_num_q;
    nxt_en_d  = nxt_en_q;
    pend_d    = pend_q;
    // Deferred update lands on a carry edge so the live ratio never changes mid-period.
    if (pend_q && en_q && sum[DW]) begin
      num_d  = nxt_num_q;
      en_d   = nxt_en_q;
      pend_d = 1'b0;
      // Keep only the carry so the channel still emits its last pulse before going idle.
      if (!nxt_en_q) acc_d = {1'b1, {DW{1'b0}}};
    end
    if (align) begin
      acc_d = '0;
      gen_d = 1'b0;
      if (pend_q) begin
        num_d  = nxt_num_q;
        en_d   = nxt_en_q;
        pend_d = 1'b0;
      end
    end
    if (ld) begin
      if (imm || align || !en_q) begin
        num_d  = num_i;
        en_d   = en_i;
        acc_d  = '0;
        pend_d = 1'b0;
      end else begin
        nxt_num_d = num_i;
        nxt_en_d  = en_i;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      num_q     <= DW'(FD0);
      en_q      <= 1'(EN0);
      nxt_num_q <= '0;
      nxt_en_q  <= 1'b0;
      pend_q    <= 1'b0;
      gen_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      num_q     <= num_d;
      en_q      <= en_d;
      nxt_num_q <= nxt_num_d;
      nxt_en_q  <= nxt_en_d;
      pend_q    <= pend_d;
      gen_q     <= gen_d;
    end
  end

  assign gen  = gen_q;
  assign pend = pend_q;
endmodule

// File: rtl/gearbox_mc.sv
// Multi-channel fractional clock-enable generator with a valid/ready config port.
module gearbox_mc
  import gearbox_pkg::*;
#(
  parameter int DW  = 8,
  parameter int NCH = 4,
  parameter int FD0 = 2**(DW-1)-1,
  parameter int EN0 = 1,
  localparam int CW = cw(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_chan,
  input  logic [DW-1:0]  cfg_num,
  input  logic           cfg_en,
  input  logic           cfg_imm,
  input  logic           align,
  output logic [NCH-1:0] gen,
  output logic [NCH-1:0] pend,
  output logic           cfg_err
);
  logic [NCH-1:0] ld, pend_w, gen_w;
  logic           chan_ok, cfg_err_d, cfg_err_q;

  // Out-of-range channels always look ready so a bad request drains and flags an error.
  always_comb begin
    chan_ok   = 1'b0;
    cfg_ready = 1'b1;
    ld        = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_chan == CW'(c)) begin
        chan_ok   = 1'b1;
        cfg_ready = !pend_w[c];
      end
    end
    for (int c = 0; c < NCH; c++)
      ld[c] = cfg_valid && cfg_ready && (cfg_chan == CW'(c));
    cfg_err_d = cfg_valid && !chan_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) cfg_err_q <= 1'b0;
    else       cfg_err_q <= cfg_err_d;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    gearbox_ch #(.DW(DW), .FD0(FD0), .EN0(EN0)) u_ch (
      .clk   (clk),
      .reset (reset),
      .ld    (ld[c]),
      .imm   (cfg_imm),
      .align (align),
      .num_i (cfg_num),
      .en_i  (cfg_en),
      .gen   (gen_w[c]),
      .pend  (pend_w[c])
    );
  end

  assign gen     = gen_w;
  assign pend    = pend_w;
  assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_gearbox_mc.sv
// Directed bench for gearbox_mc at DW=4, NCH=3 (reset num=7, i.e. half rate).
module tb_gearbox_mc;
  logic       clk = 1'b0;
  logic       reset, cfg_valid, cfg_ready, cfg_en, cfg_imm, align, cfg_err;
  logic [1:0] cfg_chan;
  logic [3:0] cfg_num;
  logic [2:0] gen, pend;
  int n_chk = 0, n_pass = 0;
  int c0, c1, c2, n;

  always #5 clk = ~clk;

  gearbox_mc #(.DW(4), .NCH(3)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_num(cfg_num), .cfg_en(cfg_en), .cfg_imm(cfg_imm),
    .align(align), .gen(gen), .pend(pend), .cfg_err(cfg_err)
  );

  typedef struct {
    logic       rst, v;
    logic [1:0] ch;
    logic [3:0] num;
    logic       en, imm, al;
    logic [3:0] ck;  // check mask: gen, pend, ready, err
    logic [2:0] g, p;
    logic       r, e;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(input logic rst, v, input logic [1:0] ch, input logic [3:0] num,
                              input logic en, imm, al, input logic [3:0] ck,
                              input logic [2:0] g, p, input logic r, e);
    vec_t t;
    t.rst = rst; t.v = v; t.ch = ch; t.num = num; t.en = en; t.imm = imm; t.al = al;
    t.ck = ck; t.g = g; t.p = p; t.r = r; t.e = e;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input logic [1:0] ch, input logic [3:0] num, input logic en, imm, rdy);
    cfg_valid = 1'b1; cfg_chan = ch; cfg_num = num; cfg_en = en; cfg_imm = imm;
    #1;
    chk($sformatf("send_ready_ch%0d", ch), 32'(cfg_ready), 32'(rdy));
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_chan = 2'd0; cfg_num = 4'd0;
    cfg_en = 1'b0; cfg_imm = 1'b0; align = 1'b0;

    // reset, release, then a dropped request to nonexistent channel 3
    tbl[0]  = mk(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1101, 3'b000, 3'b000, 1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'b000, 3'b000, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'b000, 3'b000, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'b000, 3'b000, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b000, 3'b000, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b111, 3'b000, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b000, 3'b000, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b111, 3'b000, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b000, 3'b000, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 2'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'b1111, 3'b111, 3'b000, 1'b1, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1101, 3'b000, 3'b000, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1101, 3'b111, 3'b000, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; cfg_valid = tbl[i].v; cfg_chan = tbl[i].ch; cfg_num = tbl[i].num;
      cfg_en = tbl[i].en; cfg_imm = tbl[i].imm; align = tbl[i].al;
      #1;
      if (tbl[i].ck[1]) chk($sformatf("v%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].r));
      tick();
      if (tbl[i].ck[3]) chk($sformatf("v%0d_gen", i), 32'(gen), 32'(tbl[i].g));
      if (tbl[i].ck[2]) chk($sformatf("v%0d_pend", i), 32'(pend), 32'(tbl[i].p));
      if (tbl[i].ck[0]) chk($sformatf("v%0d_err", i), 32'(cfg_err), 32'(tbl[i].e));
    end
    cfg_valid = 1'b0;

    // immediate ratio: ch1 num=2 -> acc 3,6,9,12,15,2(carry), pulse one edge later
    send(2'd1, 4'd2, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("imm_lat%0d", i), 32'(gen[1]), 32'(i == 7));
    end
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      c0 += int'(gen[0]); c1 += int'(gen[1]); c2 += int'(gen[2]);
    end
    chk("imm_cnt_ch1", 32'(c1), 32'd3);
    chk("imm_cnt_ch0", 32'(c0), 32'd8);
    chk("imm_cnt_ch2", 32'(c2), 32'd8);

    // deferred: ch2 slowest rate, then num=15 queued until its carry at M+16
    send(2'd2, 4'd0, 1'b1, 1'b1, 1'b1);               // edge M
    tick();
    chk("slow_gen_m1", 32'(gen[2]), 32'd0);
    send(2'd2, 4'd15, 1'b1, 1'b0, 1'b1);              // edge M+2
    chk("defer_pend", 32'(pend), 32'b100);
    cfg_chan = 2'd2;
    #1;
    chk("defer_not_ready", 32'(cfg_ready), 32'd0);
    send(2'd0, 4'd3, 1'b1, 1'b1, 1'b1);               // edge M+3, other channel accepted
    send(2'd2, 4'd7, 1'b1, 1'b1, 1'b0);               // edge M+4, stalled and dropped
    send(2'd1, 4'd5, 1'b1, 1'b1, 1'b1);               // edge M+5
    chk("defer_pend_others", 32'(pend[1:0]), 32'd0);
    for (int i = 6; i <= 22; i++) begin
      tick();
      chk($sformatf("defer_pend_m%0d", i), 32'(pend[2]), 32'(i < 16));
      chk($sformatf("defer_gen_m%0d", i), 32'(gen[2]), 32'(i >= 17));
    end

    // align: all channels num=5, ch0 update pending, ch1 transfer same cycle as align
    send(2'd2, 4'd5, 1'b1, 1'b1, 1'b1);
    send(2'd0, 4'd5, 1'b1, 1'b0, 1'b1);
    chk("align_pre_pend", 32'(pend), 32'b001);
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_num = 4'd5; cfg_en = 1'b1; cfg_imm = 1'b0;
    align = 1'b1;
    #1;
    chk("align_ready_ch1", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0; align = 1'b0;
    chk("align_pend", 32'(pend), 32'd0);
    chk("align_gen", 32'(gen), 32'd0);
    c0 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("align_gen_a%0d", i), 32'(gen),
          (i == 4 || i == 7 || i == 9 || i == 12 || i == 15 || i == 17 || i == 20) ? 32'd7 : 32'd0);
      if (i >= 5) c0 += int'(gen[0]);
    end
    chk("align_cnt", 32'(c0), 32'd6);

    // deferred disable of ch0: one last pulse at its carry, then silence
    send(2'd0, 4'd5, 1'b0, 1'b0, 1'b1);
    chk("dis_pend_set", 32'(pend[0]), 32'd1);
    n = 0;
    while (pend[0] && n < 20) begin
      tick();
      n++;
    end
    chk("dis_pend_clr", 32'(pend[0]), 32'd0);
    tick();
    chk("dis_final_pulse", 32'(gen[0]), 32'd1);
    c0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      c0 += int'(gen[0]);
    end
    chk("dis_silent", 32'(c0), 32'd0);

    // reset wins over align with ch2 pending; all channels back to num=7 enabled
    send(2'd2, 4'd1, 1'b1, 1'b0, 1'b1);
    chk("rst_pre_pend", 32'(pend), 32'b100);
    reset = 1'b1; align = 1'b1;
    tick();
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_gen", 32'(gen), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    reset = 1'b0; align = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("rst_gen_r%0d", i), 32'(gen), (i == 3 || i == 5) ? 32'd7 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
